// File: rtl/order_ingress_arbiter.sv
// order_ingress_arbiter
//   Collects order words from up to N_SRC sources over valid/ready and picks
//   one source round-robin. The chosen word is held on eng_payload for one
//   cycle before the engine strobe. A quiet gap of ENGINE_GAP cycles after the
//   strobe lets the engine finish its scan, cancel and insert work before the
//   next order is accepted.
//
//   Optional build macro: CANCEL_PRIORITY_EN
//     When defined, requesting sources whose word has bit 31 (cancel) set win
//     over non-cancel requests. Round-robin order still applies within the
//     winning class. When undefined, bit 31 plays no part in arbitration.
//
// Ports
//   CLK, RESET        clock and synchronous active-high reset
//   src_valid[N_SRC]  per-source order offered
//   src_data          32-bit order word per source, source i at [32*i +: 32]
//   src_ready[N_SRC]  one-hot accept; combinational, asserted only in IDLE
//   eng_payload[32]   order word presented to the engine
//   eng_packet_ready  one-cycle registered strobe to the engine
//   busy              high in every state except IDLE
//   grant_idx[3]      index of the most recently accepted source
//   orders_issued     strobes issued so far; wraps modulo 2^CNT_W
module order_ingress_arbiter #(
  parameter int N_SRC      = 4,
  parameter int ENGINE_GAP = 36,
  parameter int CNT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic [32*N_SRC-1:0]  src_data,
  output logic [N_SRC-1:0]     src_ready,
  output logic [31:0]          eng_payload,
  output logic                 eng_packet_ready,
  output logic                 busy,
  output logic [2:0]           grant_idx,
  output logic [CNT_W-1:0]     orders_issued
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int GAP_W = $clog2(ENGINE_GAP + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ISSUE   = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         rr_ptr;
  logic [GAP_W-1:0]   gap_cnt;
  logic [N_SRC-1:0]   req;
  logic [2:0]         winner;
  logic               win_vld;
  logic               hs;

  // Request class used for arbitration.
`ifdef CANCEL_PRIORITY_EN
  logic [N_SRC-1:0] cancel_req;

  always_comb begin
    cancel_req = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cancel_req[i] = src_valid[i] & src_data[32*i+31];
    end
    // Cancels form their own class; fall back to all requests only when no
    // cancel is pending.
    req = (|cancel_req) ? cancel_req : src_valid;
  end
`else
  always_comb begin
    req = src_valid;
  end
`endif

  // Round-robin search starting at rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = 3'd0;
    win_vld = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!win_vld && req[IDX_W'(idx)]) begin
        win_vld = 1'b1;
        winner  = 3'(idx);
      end
    end
  end

  assign hs        = (state == IDLE) && win_vld;
  assign src_ready = hs ? (N_SRC'(1) << winner) : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = PRESENT;
      PRESENT: state_nxt = ISSUE;
      ISSUE:   state_nxt = GAP;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: handshake capture, strobe generation and gap timing.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state            <= IDLE;
      rr_ptr           <= 3'd0;
      gap_cnt          <= '0;
      eng_payload      <= 32'd0;
      eng_packet_ready <= 1'b0;
      grant_idx        <= 3'd0;
      orders_issued    <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        eng_payload <= src_data[32*winner +: 32];
        grant_idx   <= winner;
        rr_ptr      <= (winner == 3'(N_SRC-1)) ? 3'd0 : winner + 3'd1;
      end
      // Registered strobe: set while leaving PRESENT so it is high exactly
      // during the ISSUE cycle.
      eng_packet_ready <= (state == PRESENT);
      if (state == ISSUE) begin
        orders_issued <= orders_issued + CNT_W'(1);
        gap_cnt       <= GAP_W'(ENGINE_GAP - 1);
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_order_ingress_arbiter.sv
module tb_order_ingress_arbiter;

  localparam int N_SRC      = 4;
  localparam int ENGINE_GAP = 36;
  localparam int CNT_W      = 4;

  logic               CLK;
  logic               RESET;
  logic [N_SRC-1:0]   src_valid;
  logic [32*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_ready;
  logic [31:0]        eng_payload;
  logic               eng_packet_ready;
  logic               busy;
  logic [2:0]         grant_idx;
  logic [CNT_W-1:0]   orders_issued;

  int checks   = 0;
  int failures = 0;

  order_ingress_arbiter #(
    .N_SRC(N_SRC), .ENGINE_GAP(ENGINE_GAP), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .eng_payload(eng_payload),
    .eng_packet_ready(eng_packet_ready), .busy(busy), .grant_idx(grant_idx),
    .orders_issued(orders_issued)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    src_data[32*i +: 32] = w;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    int k;
    int last_hs;
    int last_strobe;
    logic [3:0] exp_rdy;

    RESET     = 1'b1;
    src_valid = '0;
    src_data  = '0;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_payload", eng_payload, 32'd0);
    chk("rst_strobe", 32'(eng_packet_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    chk("rst_orders", 32'(orders_issued), 32'd0);

    // Single order from source 0
    RESET = 1'b0;
    tick();
    set_word(0, 32'h00640A01);
    src_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(src_ready), 32'h1);
    tick();
    src_valid = '0;
    #1;
    chk("t1_payload", eng_payload, 32'h00640A01);
    chk("t1_present_strobe", 32'(eng_packet_ready), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_off", 32'(src_ready), 32'd0);
    tick();
    chk("t1_strobe", 32'(eng_packet_ready), 32'd1);
    chk("t1_orders_before", 32'(orders_issued), 32'd0);
    tick();
    chk("t1_strobe_off", 32'(eng_packet_ready), 32'd0);
    chk("t1_orders", 32'(orders_issued), 32'd1);
    wait_idle();

    // Fairness and spacing with all sources asserting from rr_ptr=0
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < N_SRC; i++) set_word(i, 32'h10000000 + i);
    src_valid   = 4'b1111;
    cyc         = 0;
    n           = 0;
    last_hs     = -1;
    last_strobe = -1;
    while (n < 5 && cyc < 300) begin
      #1;
      if (src_ready != '0) begin
        exp_rdy = 4'b0001 << (n % 4);
        chk("rr_grant", 32'(src_ready), 32'(exp_rdy));
        if (last_hs >= 0) chk("rr_spacing", 32'(cyc - last_hs), 32'd39);
        last_hs = cyc;
        n++;
      end
      if (eng_packet_ready) begin
        if (last_strobe >= 0) chk("strobe_spacing_ok", 32'(cyc - last_strobe >= 39), 32'd1);
        last_strobe = cyc;
      end
      tick();
      cyc++;
    end
    chk("rr_hs_count", 32'(n), 32'd5);
    #1;
    chk("rr_wrap_grant", 32'(grant_idx), 32'd0);
    chk("rr_payload", eng_payload, 32'h10000000);
    chk("rr_orders", 32'(orders_issued), 32'd4);

    // Source 2 requests during the busy window
    set_word(2, 32'h01500507);
    src_valid = 4'b0100;
    k = 0;
    while (k < 60) begin
      #1;
      if (!busy) break;
      if (src_ready != '0) chk("gap_ready_low", 32'(src_ready), 32'd0);
      tick();
      k++;
    end
    chk("gap_busy_cycles", 32'(k), 32'd38);
    chk("gap_first_idle_ready", 32'(src_ready), 32'h4);
    chk("gap_orders", 32'(orders_issued), 32'd5);
    tick();
    set_word(2, 32'hDEADBEEF);
    src_valid = '0;
    #1;
    chk("gap_payload", eng_payload, 32'h01500507);
    chk("gap_grant", 32'(grant_idx), 32'd2);
    tick();
    chk("hold_payload", eng_payload, 32'h01500507);
    wait_idle();
    chk("orders_6", 32'(orders_issued), 32'd6);

    // Reset while in PRESENT (rr_ptr is 3, so source 1 wins)
    set_word(1, 32'h00640A01);
    src_valid = 4'b0010;
    #1;
    chk("mid_ready", 32'(src_ready), 32'h2);
    tick();
    src_valid = '0;
    RESET     = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    tick();
    #1;
    chk("mid_strobe", 32'(eng_packet_ready), 32'd0);
    chk("mid_busy_rst", 32'(busy), 32'd0);
    chk("mid_payload", eng_payload, 32'd0);
    chk("mid_grant", 32'(grant_idx), 32'd0);
    chk("mid_orders", 32'(orders_issued), 32'd0);
    RESET = 1'b0;
    tick();
    chk("mid_no_strobe", 32'(eng_packet_ready), 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);

    // Buy on source 1 vs cancel on source 3, rr_ptr=0
    set_word(1, 32'h00640A01);
    set_word(3, 32'h80000005);
    src_valid = 4'b1010;
    #1;
`ifdef CANCEL_PRIORITY_EN
    chk("cxl_ready", 32'(src_ready), 32'h8);
`else
    chk("cxl_ready", 32'(src_ready), 32'h2);
`endif
    tick();
    src_valid = '0;
    #1;
`ifdef CANCEL_PRIORITY_EN
    chk("cxl_grant", 32'(grant_idx), 32'd3);
    chk("cxl_payload", eng_payload, 32'h80000005);
`else
    chk("cxl_grant", 32'(grant_idx), 32'd1);
    chk("cxl_payload", eng_payload, 32'h00640A01);
`endif
    wait_idle();
    chk("cxl_orders", 32'(orders_issued), 32'd1);

    // Counter wrap: 16 more orders, 17 in total since reset
    set_word(0, 32'h00010203);
    src_valid = 4'b0001;
    cyc = 0;
    n   = 0;
    while (n < 16 && cyc < 800) begin
      #1;
      if (src_ready != '0) n++;
      tick();
      cyc++;
    end
    chk("wrap_hs_count", 32'(n), 32'd16);
    src_valid = '0;
    wait_idle();
    chk("wrap_orders", 32'(orders_issued), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
